// File: rtl/hc4_trace_pkg.sv
// ============================================================================
// Module      : hc4_trace_pkg
// Description : Shared state encoding and entry layout for the hc4 trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc4_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int ENTRY_W  = 24;
    localparam int PC_W     = 12;
    localparam int INSN_W   = 8;
    localparam int ALU_W    = 4;
    localparam int PC_LSB   = 12;
    localparam int INSN_LSB = 4;

endpackage

`default_nettype wire

// File: rtl/hc4_trace_fifo.sv
// ============================================================================
// Module      : hc4_trace_fifo
// Description : Synchronous FIFO holding trace entries; reads are show-ahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc4_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the same cycle frees a slot.
    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/hc4_trace_buffer.sv
// ============================================================================
// Module      : hc4_trace_buffer
// Description : Triggered instruction-trace capture for the hc4 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc4_trace_buffer
    import hc4_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                trace_valid,
    input  logic [11:0]         pc_in,
    input  logic [7:0]          instruction_in,
    input  logic [3:0]          alu_in,
    input  logic                arm,
    input  logic                clear,
    input  logic [11:0]         trigger_pc,
    input  logic [CNT_W-1:0]    capture_len,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [ENTRY_W-1:0]  rd_data,
    output logic [CNT_W-1:0]    count,
    output logic [7:0]          overflow_cnt,
    output logic [1:0]          state
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    trace_state_e       state_q, state_d;
    logic [CNT_W-1:0]   captured_q, captured_d;
    logic [CNT_W-1:0]   eff_len_q, eff_len_d;
    logic [7:0]         overflow_q, overflow_d;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] wr_entry;
    logic               trigger_hit, want_write;
    logic [CNT_W-1:0]   len_sample, len_now;

    always_comb begin
        wr_entry = '0;
        wr_entry[PC_LSB   +: PC_W]   = pc_in;
        wr_entry[INSN_LSB +: INSN_W] = instruction_in;
        wr_entry[0        +: ALU_W]  = alu_in;
    end

    always_comb begin
        trigger_hit = (state_q == ST_ARMED) && trace_valid && (pc_in == trigger_pc);
        want_write  = trigger_hit || ((state_q == ST_CAPTURE) && trace_valid);
        fifo_pop    = !fifo_empty && rd_ready && !clear;
        fifo_push   = want_write && (!fifo_full || fifo_pop) && !clear;
        len_sample  = ((capture_len == '0) || (capture_len > DEPTH_C)) ? DEPTH_C : capture_len;
        len_now     = trigger_hit ? len_sample : eff_len_q;

        state_d    = state_q;
        captured_d = captured_q;
        eff_len_d  = eff_len_q;
        overflow_d = overflow_q;

        if (clear) begin
            state_d    = ST_IDLE;
            captured_d = '0;
            overflow_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm) state_d = ST_ARMED;
                ST_ARMED: if (trigger_hit) begin
                    state_d    = ST_CAPTURE;
                    captured_d = '0;
                    eff_len_d  = len_sample;
                end
                default: state_d = state_q;
            endcase

            // Dropped samples do not advance the length counter.
            if (want_write) begin
                if (fifo_push) begin
                    captured_d = (trigger_hit ? '0 : captured_q) + 1'b1;
                    if (captured_d == len_now) state_d = ST_DONE;
                end else if (overflow_q != 8'hFF) begin
                    overflow_d = overflow_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            captured_q <= '0;
            eff_len_q  <= DEPTH_C;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            eff_len_q  <= eff_len_d;
            overflow_q <= overflow_d;
        end
    end

    hc4_trace_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (nReset),
        .flush   (clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wr_entry),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_valid     = !fifo_empty;
    assign count        = fifo_count;
    assign overflow_cnt = overflow_q;
    assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hc4_trace_buffer.sv
// ============================================================================
// Module      : tb_hc4_trace_buffer
// Description : Randomized self-checking bench for hc4_trace_buffer with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hc4_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             nReset = 1'b0;
    logic             trace_valid = 1'b0;
    logic [11:0]      pc_in = '0;
    logic [7:0]       instruction_in = '0;
    logic [3:0]       alu_in = '0;
    logic             arm = 1'b0;
    logic             clear = 1'b0;
    logic [11:0]      trigger_pc = '0;
    logic [CNT_W-1:0] capture_len = '0;
    logic             rd_ready = 1'b0;
    logic             rd_valid;
    logic [23:0]      rd_data;
    logic [CNT_W-1:0] count;
    logic [7:0]       overflow_cnt;
    logic [1:0]       state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents as a queue plus the capture bookkeeping.
    int          m_state = 0;
    int          m_cap = 0;
    int          m_len = DEPTH;
    int          m_ovf = 0;
    int          m_pushes = 0;
    logic [23:0] m_q[$];

    always #5 clk = ~clk;

    hc4_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .nReset         (nReset),
        .trace_valid    (trace_valid),
        .pc_in          (pc_in),
        .instruction_in (instruction_in),
        .alu_in         (alu_in),
        .arm            (arm),
        .clear          (clear),
        .trigger_pc     (trigger_pc),
        .capture_len    (capture_len),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .count          (count),
        .overflow_cnt   (overflow_cnt),
        .state          (state)
    );

    function automatic logic [23:0] m_front();
        return (m_q.size() != 0) ? m_q[0] : 24'h0;
    endfunction

    task automatic m_reset();
        m_state = 0; m_cap = 0; m_len = DEPTH; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic tick();
        logic [23:0] e;
        bit pop, trig, wr;
        @(posedge clk);
        pop  = (m_q.size() != 0) && rd_ready;
        trig = (m_state == 1) && trace_valid && (pc_in == trigger_pc);
        wr   = trig || ((m_state == 2) && trace_valid);
        e    = {pc_in, instruction_in, alu_in};
        if (clear) begin
            m_q.delete(); m_state = 0; m_cap = 0; m_ovf = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (trig) begin
                m_state = 2; m_cap = 0;
                m_len = (capture_len == 0 || int'(capture_len) > DEPTH) ? DEPTH : int'(capture_len);
            end else if (arm && (m_state == 0 || m_state == 3)) begin
                m_state = 1;
            end
            if (wr) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(e); m_pushes++; m_cap++;
                    if (m_cap == m_len) m_state = 3;
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
            end
        end
        #1;
    endtask

    task automatic quiet();
        trace_valid = 1'b0; arm = 1'b0; clear = 1'b0;
    endtask

    task automatic sample(input logic [11:0] pc);
        trace_valid = 1'b1; pc_in = pc;
        instruction_in = 8'($urandom); alu_in = 4'($urandom);
    endtask

    task automatic start_capture(input logic [11:0] tpc, input logic [CNT_W-1:0] len);
        trigger_pc = tpc; capture_len = len; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 24'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (overflow_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_overflow: got %0d want 0", overflow_cnt); end
        @(negedge clk); nReset = 1'b1; m_reset();
    endtask

    task automatic test_basic_capture();
        logic [23:0] exp5;
        start_capture(12'h005, CNT_W'(3));
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL basic_armed: got %0d want 1", state); end
        for (int pc = 3; pc <= 9; pc++) begin
            sample(12'(pc));
            exp5 = {12'(pc), instruction_in, alu_in};
            tick();
            if (pc == 5) begin
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp5) begin
                    n_bad++; $display("FAIL basic_latency: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, exp5);
                end
            end
        end
        quiet();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL basic_done: got %0d want 3", state); end
        n_cmp++; if (count !== CNT_W'(3)) begin n_bad++; $display("FAIL basic_count: got %0d want 3", count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_data[23:12] !== 12'(5 + i) || rd_data !== m_front()) begin
                n_bad++; $display("FAIL basic_order%0d: got %h want pc %h entry %h", i, rd_data, 5 + i, m_front());
            end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin
            n_bad++; $display("FAIL basic_empty: got v=%b d=%h want v=0 d=0", rd_valid, rd_data);
        end
    endtask

    // Four leftover entries from a completed capture leave 12 free slots for length 16.
    task automatic test_overflow();
        start_capture(12'h100, CNT_W'(4));
        for (int i = 0; i < 4; i++) begin sample(12'h100 + 12'(i)); tick(); end
        quiet();
        n_cmp++; if (state !== 2'd3 || count !== CNT_W'(4)) begin
            n_bad++; $display("FAIL ovf_pre: got st=%0d cnt=%0d want st=3 cnt=4", state, count);
        end
        start_capture(12'h200, CNT_W'(0));
        for (int i = 0; i < 20; i++) begin sample(12'h200 + 12'(i)); tick(); end
        quiet();
        n_cmp++; if (count !== CNT_W'(16)) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", count); end
        n_cmp++; if (overflow_cnt !== 8'd8) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 8", overflow_cnt); end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL ovf_state: got %0d want 2", state); end
    endtask

    task automatic test_full_push_pop();
        logic [23:0] oldest;
        oldest = m_front();
        n_cmp++; if (rd_data !== oldest) begin n_bad++; $display("FAIL fpp_head: got %h want %h", rd_data, oldest); end
        sample(12'h2F0); rd_ready = 1'b1;
        tick();
        quiet(); rd_ready = 1'b0;
        n_cmp++; if (count !== CNT_W'(16)) begin n_bad++; $display("FAIL fpp_count: got %0d want 16", count); end
        n_cmp++; if (overflow_cnt !== 8'd8) begin n_bad++; $display("FAIL fpp_ovf: got %0d want 8", overflow_cnt); end
        n_cmp++; if (rd_data !== m_front() || rd_data === oldest) begin
            n_bad++; $display("FAIL fpp_pop: got %h want %h", rd_data, m_front());
        end
    endtask

    task automatic test_overflow_saturate();
        for (int i = 0; i < 260; i++) begin sample(12'($urandom)); tick(); end
        quiet();
        n_cmp++; if (overflow_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_ovf: got %0d want 255", overflow_cnt); end
        n_cmp++; if (state !== 2'd2 || count !== CNT_W'(16)) begin
            n_bad++; $display("FAIL sat_state: got st=%0d cnt=%0d want st=2 cnt=16", state, count);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); quiet();
        n_cmp++; if (state !== 2'd0 || count !== '0 || overflow_cnt !== 8'd0) begin
            n_bad++; $display("FAIL clr_flush: got st=%0d cnt=%0d ovf=%0d want 0/0/0", state, count, overflow_cnt);
        end
        start_capture(12'h050, CNT_W'(10));
        for (int i = 0; i < 5; i++) begin sample(12'h050 + 12'(i)); tick(); end
        quiet();
        n_cmp++; if (state !== 2'd2 || count !== CNT_W'(5)) begin
            n_bad++; $display("FAIL clr_pre: got st=%0d cnt=%0d want st=2 cnt=5", state, count);
        end
        clear = 1'b1; arm = 1'b1; rd_ready = 1'b1; sample(12'h055);
        tick();
        quiet(); rd_ready = 1'b0;
        n_cmp++; if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || rd_data !== 24'h0) begin
            n_bad++; $display("FAIL clr_arm: got st=%0d cnt=%0d v=%b d=%h want 0/0/0/0", state, count, rd_valid, rd_data);
        end
    endtask

    task automatic test_reset_mid_capture();
        start_capture(12'h030, CNT_W'(8));
        for (int i = 0; i < 3; i++) begin sample(12'h030 + 12'(i)); tick(); end
        quiet();
        @(posedge clk); #3;
        nReset = 1'b0; #1;
        n_cmp++; if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || rd_data !== 24'h0 || overflow_cnt !== 8'd0) begin
            n_bad++; $display("FAIL rst_async: got st=%0d cnt=%0d v=%b d=%h ovf=%0d want all 0", state, count, rd_valid, rd_data, overflow_cnt);
        end
        nReset = 1'b1; m_reset();
        start_capture(12'h000, CNT_W'(2));
        for (int i = 0; i < 3; i++) begin sample(12'(i)); tick(); end
        quiet();
        n_cmp++; if (state !== 2'd3 || count !== CNT_W'(2)) begin
            n_bad++; $display("FAIL rst_recap: got st=%0d cnt=%0d want st=3 cnt=2", state, count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (rd_data[23:12] !== 12'(i) || rd_data !== m_front()) begin
                n_bad++; $display("FAIL rst_order%0d: got %h want %h", i, rd_data, m_front());
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    // Lengths above DEPTH behave as DEPTH: DONE arrives with the 16th write.
    task automatic test_len_clamp();
        start_capture(12'h7A0, CNT_W'(20));
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample(12'h7A0 + 12'(i)); tick();
            if (i == 14) begin
                n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL clamp_15: got %0d want 2", state); end
            end
        end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL clamp_16: got %0d want 3", state); end
        sample(12'h7B0); tick(); quiet();
        n_cmp++; if (count !== CNT_W'(m_q.size()) || count !== '0) begin
            n_bad++; $display("FAIL clamp_nowrite: got %0d want 0", count);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_random_drain();
        int base, pops, cyc;
        clear = 1'b1; tick(); quiet();
        base = m_pushes; pops = 0; cyc = 0;
        while (cyc < 3000 && ((m_pushes - base) < 50 || m_q.size() != 0)) begin
            quiet();
            if ((m_pushes - base) < 50) begin
                if (m_state == 0 || m_state == 3) begin
                    arm = 1'b1;
                    trigger_pc = 12'($urandom);
                    capture_len = CNT_W'($urandom_range(20, 1));
                end else if ($urandom_range(3, 0) != 0) begin
                    sample((m_state == 1 && $urandom_range(2, 0) == 0) ? trigger_pc : 12'($urandom));
                end
                rd_ready = 1'($urandom);
            end else begin
                rd_ready = 1'b1;
            end
            if (m_q.size() != 0) begin
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== m_front()) begin
                    n_bad++; $display("FAIL rand_data: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, m_front());
                end
            end
            if (rd_valid && rd_ready) pops++;
            tick();
            cyc++;
        end
        quiet(); rd_ready = 1'b0;
        n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL rand_timeout: got %0d cycles want < 3000", cyc); end
        n_cmp++; if (pops != (m_pushes - base) || count !== '0) begin
            n_bad++; $display("FAIL rand_total: got pops=%0d cnt=%0d want pops=%0d cnt=0", pops, count, m_pushes - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_overflow();
        test_full_push_pop();
        test_overflow_saturate();
        test_clear();
        test_reset_mid_capture();
        test_len_clamp();
        test_random_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/hc4_trace_buffer.md
HC4_TRACE_BUFFER -- requirements
Module: hc4_trace_buffer

Interface
REQ-001 Parameter DEPTH, 16, trace FIFO entries (power of two, 4..64).
REQ-002 Parameter CNT_W, 5, width of count and capture_len, equal to log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 trace_valid  input  1  one-cycle strobe: hc4 executed the instruction on pc_in/instruction_in/alu_in.
REQ-006 pc_in  input  12  hc4 program counter (pc_out).
REQ-007 instruction_in  input  8  hc4 instruction (instruction_out).
REQ-008 alu_in  input  4  hc4 ALU result (alu_out).
REQ-009 arm  input  1  pulse: arm the trigger.
REQ-010 clear  input  1  pulse: abort, flush, return to IDLE.
REQ-011 trigger_pc  input  12  PC value that starts capture.
REQ-012 capture_len  input  CNT_W  entries to capture after the trigger, trigger sample included.
REQ-013 rd_valid  output  1  FIFO non-empty; rd_data valid.
REQ-014 rd_ready  input  1  consumer accepts rd_data.
REQ-015 rd_data  output  24  {pc, instruction, alu}, pc in [23:12].
REQ-016 count  output  CNT_W  current FIFO occupancy.
REQ-017 overflow_cnt  output  8  dropped samples, saturating.
REQ-018 state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Function
REQ-019 Entry SHALL be {pc_in, instruction_in, alu_in}, sampled on the edge where trace_valid=1.
REQ-020 IDLE or DONE + arm -> ARMED; arm in ARMED/CAPTURE ignored; arm does not flush the FIFO.
REQ-021 ARMED + trace_valid + pc_in==trigger_pc -> CAPTURE; that sample SHALL be written; other samples ignored.
REQ-022 CAPTURE: each trace_valid with FIFO not full writes one entry and increments the captured counter.
REQ-023 When captured counter reaches effective length, SHALL enter DONE the next edge; no further writes in DONE/IDLE.
REQ-024 Effective length = capture_len, sampled on the trigger edge; 0 or >DEPTH clamps to DEPTH.
REQ-025 Full with no pop and trace_valid in CAPTURE: sample dropped, overflow_cnt +1 (saturate at 255), not counted toward length.
REQ-026 Full with simultaneous pop and push: both accepted, count unchanged, no overflow.
REQ-027 Pop when rd_valid && rd_ready; rd_valid = (count != 0); rd_data = oldest entry, 0 when empty.
REQ-028 Write-to-read latency: entry written at edge N appears on rd_data/rd_valid after edge N (one cycle).
REQ-029 Pointers SHALL wrap modulo DEPTH; count never exceeds DEPTH.
REQ-030 clear SHALL override arm and all writes/pops: state IDLE, FIFO empty, overflow_cnt 0, next edge.
REQ-031 Draining SHALL be permitted in every state.

Reset
REQ-032 nReset low: state=IDLE, pointers/count/captured=0, overflow_cnt=0, rd_valid=0, rd_data=0 immediately.
REQ-033 Storage array SHALL NOT be reset; reset mid-capture discards all entries.

Structure
REQ-034 Package hc4_trace_pkg SHALL hold state encoding, ENTRY_W=24, and the field offsets PC_LSB=12, INSN_LSB=4.
REQ-035 Sub-module hc4_trace_fifo (sync FIFO with push/pop/full/empty/count) SHALL hold storage; FSM, trigger, and counters stay in the top.

Verification
REQ-036 arm, trigger_pc=0x005, capture_len=3, PCs 0x003..0x009 each valid -> entries PC 0x005,0x006,0x007; state DONE; count=3.
REQ-037 DEPTH=16, capture_len=0, rd_ready=0, 20 valid samples after trigger -> count=16, overflow_cnt=4, state stays CAPTURE.
REQ-038 Full FIFO, rd_ready=1 with trace_valid=1 same cycle -> count stays 16, overflow_cnt unchanged, oldest popped.
REQ-039 clear and arm in same cycle during CAPTURE with count=5 -> next cycle state IDLE, count=0, rd_valid=0.
REQ-040 nReset low mid-capture for 1 ns off-edge -> outputs reset immediately; after release, arm and re-trigger captures from PC 0x000 correctly.
REQ-041 rd_ready toggled randomly over 50 samples -> rd_data order equals write order, no duplicate or lost entries.
